// File: rtl/uart8_tx_arbiter.sv
// Round-robin scheduler sharing one Uart8 transmit channel among NUM_REQ
// byte producers, with an optional channel tag byte ahead of every data byte.
//
// Ports:
//   clk, rstN              board clock, asynchronous active-low reset
//   en                     arbitration enable (a frame in progress always completes)
//   reqValid/reqData       per-requester byte offer, byte i at reqData[8i+7:8i]
//   reqReady               one-cycle accept pulse to the granted requester
//   grantId                index of the requester currently or last served
//   active                 high while a transfer is in progress
//   errClr/timeoutErr      clear / sticky flag for a missing txBusy response
//   txEn/txStart/txData    Uart8 transmit controls
//   txBusy/txDone          Uart8 status (txDone is not used for sequencing)
module uart8_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter bit          TAG_ENABLE    = 1'b0,
  parameter logic [7:0]  TAG_BASE      = 8'h80,
  parameter int unsigned START_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  output logic [NUM_REQ-1:0]   reqReady,
  output logic [2:0]           grantId,
  output logic                 active,
  input  logic                 errClr,
  output logic                 timeoutErr,
  output logic                 txEn,
  output logic                 txStart,
  output logic [7:0]           txData,
  input  logic                 txBusy,
  input  logic                 txDone
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         data_q, data_d;
  logic               second_q, second_d;
  logic               start_q, start_d;
  logic [7:0]         txdata_q, txdata_d;
  logic [2:0]         grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found_c;
  logic [IDX_W-1:0]   gidx_c;
  logic [IDX_W-1:0]   cand_c;
  logic [7:0]         req_byte_c [NUM_REQ];

  // txDone is monitored only; completion is taken from the txBusy fall.
  logic unused_tx_done;
  assign unused_tx_done = txDone;

  // Unpack the flat data bus into one byte per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_byte_c[i] = reqData[8*i +: 8];
  end

  // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin : grant_search
    found_c = 1'b0;
    gidx_c  = '0;
    cand_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found_c && reqValid[cand_c]) begin
        found_c = 1'b1;
        gidx_c  = cand_c;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : next_state
    state_d  = state_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    second_d = second_q;
    start_d  = start_q;
    txdata_d = txdata_q;
    grant_d  = grant_q;
    ready_d  = '0;
    err_d    = err_q & ~errClr;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en && found_c) begin
          ready_d[gidx_c] = 1'b1;
          data_d          = req_byte_c[gidx_c];
          grant_d         = 3'(gidx_c);
          ptr_d           = IDX_W'((32'(gidx_c) + 32'd1) % NUM_REQ);
          txdata_d        = TAG_ENABLE ? 8'(TAG_BASE + 8'(gidx_c)) : req_byte_c[gidx_c];
          second_d        = 1'b0;
          start_d         = 1'b1;
          cnt_d           = CNT_W'(1);
          state_d         = ST_START;
        end
      end

      // cnt_q holds the number of cycles txStart has been high so far.
      ST_START: begin
        if (txBusy) begin
          start_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_q >= CNT_TO) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (!txBusy) begin
          if (TAG_ENABLE && !second_q) begin
            txdata_d = data_q;
            second_d = 1'b1;
            start_d  = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstN) begin : regs
    if (!rstN) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      data_q   <= '0;
      second_q <= 1'b0;
      start_q  <= 1'b0;
      txdata_q <= '0;
      grant_q  <= '0;
      ready_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      second_q <= second_d;
      start_q  <= start_d;
      txdata_q <= txdata_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign reqReady   = ready_q;
  assign grantId    = grant_q;
  assign active     = (state_q != ST_IDLE);
  assign timeoutErr = err_q;
  assign txStart    = start_q;
  assign txData     = txdata_q;
  // Enable stays up while a frame is in progress even if en has dropped.
  assign txEn       = en | active;

endmodule

// File: tb/tb_uart8_tx_arbiter.sv
// Bench for uart8_tx_arbiter: an untagged instance (a) and a tagged instance (b),
// each driven against a small Uart8 busy model.
module tb_uart8_tx_arbiter;

  localparam int BUSY_DLY = 2;
  localparam int BUSY_LEN = 6;
  localparam int NV       = 9;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        en_a, err_clr_a, terr_a, txen_a, start_a, busy_a, active_a;
  logic [3:0]  valid_a, ready_a;
  logic [31:0] data_a;
  logic [2:0]  grant_a;
  logic [7:0]  txdata_a;

  logic        en_b, err_clr_b, terr_b, txen_b, start_b, busy_b, active_b;
  logic [3:0]  valid_b, ready_b;
  logic [31:0] data_b;
  logic [2:0]  grant_b;
  logic [7:0]  txdata_b;

  logic        done_0 = 1'b0;

  int errors = 0;
  int checks = 0;

  // Uart8 busy model: busy rises 3 edges after txStart is raised, holds BUSY_LEN.
  int   mst   [2];
  int   mcnt  [2];
  logic mbusy [2];
  logic mstart[2];
  bit   mtie  [2];

  assign mstart[0] = start_a;
  assign mstart[1] = start_b;
  assign busy_a    = mbusy[0];
  assign busy_b    = mbusy[1];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        mst[m]   <= 0;
        mcnt[m]  <= 0;
        mbusy[m] <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (mtie[m]) begin
          mbusy[m] <= 1'b0;
          mst[m]   <= 0;
        end else begin
          case (mst[m])
            0: if (mstart[m] && !mbusy[m]) begin mst[m] <= 1; mcnt[m] <= 1; end
            1: if (mcnt[m] == BUSY_DLY) begin mbusy[m] <= 1'b1; mst[m] <= 2; mcnt[m] <= 1; end
               else mcnt[m] <= mcnt[m] + 1;
            default: if (mcnt[m] == BUSY_LEN) begin mbusy[m] <= 1'b0; mst[m] <= 0; end
                     else mcnt[m] <= mcnt[m] + 1;
          endcase
        end
      end
    end
  end

  uart8_tx_arbiter #(.NUM_REQ(4), .TAG_ENABLE(1'b0), .TAG_BASE(8'h80), .START_TIMEOUT(16)) u_dut_a (
    .clk(clk), .rstN(rst_n), .en(en_a), .reqValid(valid_a), .reqData(data_a),
    .reqReady(ready_a), .grantId(grant_a), .active(active_a), .errClr(err_clr_a),
    .timeoutErr(terr_a), .txEn(txen_a), .txStart(start_a), .txData(txdata_a),
    .txBusy(busy_a), .txDone(done_0)
  );

  uart8_tx_arbiter #(.NUM_REQ(4), .TAG_ENABLE(1'b1), .TAG_BASE(8'h80), .START_TIMEOUT(16)) u_dut_b (
    .clk(clk), .rstN(rst_n), .en(en_b), .reqValid(valid_b), .reqData(data_b),
    .reqReady(ready_b), .grantId(grant_b), .active(active_b), .errClr(err_clr_b),
    .timeoutErr(terr_b), .txEn(txen_b), .txStart(start_b), .txData(txdata_b),
    .txBusy(busy_b), .txDone(done_0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready_a();
    for (int n = 0; n < 50 && ready_a == 4'b0; n++) @(negedge clk);
  endtask

  task automatic wait_idle_a();
    for (int n = 0; n < 100 && active_a; n++) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [2:0]  exp_g;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[NV];
  int   cnt, pulses, frames, quiet;
  logic [3:0] rdy_bits;
  logic [7:0] fr[4];
  logic prev, seen, en_seen;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0001, 32'h000000A5, 3'd0, 8'hA5};
    vecs[1] = '{4'b1111, 32'h44332211, 3'd1, 8'h22};
    vecs[2] = '{4'b1111, 32'h44332211, 3'd2, 8'h33};
    vecs[3] = '{4'b1111, 32'h44332211, 3'd3, 8'h44};
    vecs[4] = '{4'b1111, 32'h44332211, 3'd0, 8'h11};
    vecs[5] = '{4'b0001, 32'h0000005A, 3'd0, 8'h5A};
    vecs[6] = '{4'b1001, 32'h77000066, 3'd3, 8'h77};
    vecs[7] = '{4'b0110, 32'h00998800, 3'd1, 8'h88};
    vecs[8] = '{4'b0011, 32'h0000BBAA, 3'd0, 8'hAA};

    rst_n = 1'b0;
    en_a = 1'b0; valid_a = '0; data_a = '0; err_clr_a = 1'b0;
    en_b = 1'b0; valid_b = '0; data_b = '0; err_clr_b = 1'b0;
    mtie[0] = 1'b0; mtie[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_ready",  32'(ready_a),  32'h0);
    check("rst_grant",  32'(grant_a),  32'h0);
    check("rst_active", 32'(active_a), 32'h0);
    check("rst_terr",   32'(terr_a),   32'h0);
    check("rst_start",  32'(start_a),  32'h0);
    check("rst_txdata", 32'(txdata_a), 32'h0);
    check("rst_txen",   32'(txen_a),   32'h0);
    check("rst_txen_b", 32'(txen_b),   32'h0);

    rst_n = 1'b1;
    en_a  = 1'b1;
    @(negedge clk);
    check("en_txen", 32'(txen_a), 32'h1);

    // Table-driven grants on the untagged instance.
    for (int i = 0; i < NV; i++) begin
      valid_a = vecs[i].valid;
      data_a  = vecs[i].data;
      wait_ready_a();
      check($sformatf("v%0d_ready", i),  32'(ready_a),  32'(1) << vecs[i].exp_g);
      check($sformatf("v%0d_grant", i),  32'(grant_a),  32'(vecs[i].exp_g));
      check($sformatf("v%0d_start", i),  32'(start_a),  32'h1);
      check($sformatf("v%0d_txdata", i), 32'(txdata_a), 32'(vecs[i].exp_byte));
      cnt = 0;
      while (start_a && cnt < 50) begin
        cnt++;
        @(negedge clk);
        if (cnt == 1) check($sformatf("v%0d_pulse", i), 32'(ready_a), 32'h0);
      end
      check($sformatf("v%0d_start_len", i), 32'(cnt), 32'd4);
      check($sformatf("v%0d_wait_act", i),  32'(active_a), 32'h1);
      wait_idle_a();
      check($sformatf("v%0d_idle", i), 32'(active_a), 32'h0);
    end
    valid_a = '0;
    @(negedge clk);

    // Start timeout with txBusy held low (pointer is at 1).
    mtie[0] = 1'b1;
    valid_a = 4'b0010; data_a = 32'h0000CD00;
    wait_ready_a();
    check("to1_ready", 32'(ready_a), 32'h2);
    valid_a = '0;
    cnt = 0;
    while (start_a && cnt < 100) begin cnt++; @(negedge clk); end
    check("to1_len",    32'(cnt),      32'd16);
    check("to1_terr",   32'(terr_a),   32'h1);
    check("to1_active", 32'(active_a), 32'h0);
    err_clr_a = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
    check("to1_clr", 32'(terr_a), 32'h0);

    // Second timeout with errClr held: the set wins on the timeout edge.
    err_clr_a = 1'b1;
    valid_a = 4'b0100; data_a = 32'h00EE0000;
    wait_ready_a();
    check("to2_ready", 32'(ready_a), 32'h4);
    valid_a = '0;
    cnt = 0;
    while (start_a && cnt < 100) begin cnt++; @(negedge clk); end
    check("to2_len",     32'(cnt),    32'd16);
    check("to2_setwins", 32'(terr_a), 32'h1);
    @(negedge clk);
    check("to2_clr", 32'(terr_a), 32'h0);
    err_clr_a = 1'b0;
    mtie[0] = 1'b0;

    // Tagged transfer: tag 0x82 then data 0x3C, one accept pulse.
    en_b = 1'b1;
    valid_b = 4'b0100; data_b = 32'h003C0000;
    pulses = 0; frames = 0; rdy_bits = '0; prev = 1'b0; seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ready_b != 4'b0) begin pulses++; rdy_bits |= ready_b; valid_b = '0; end
      if (start_b && !prev && frames < 4) begin fr[frames] = txdata_b; frames++; end
      prev = start_b;
      if (active_b) seen = 1'b1;
      if (seen && !active_b) break;
    end
    check("tag_pulses", 32'(pulses),   32'd1);
    check("tag_ready",  32'(rdy_bits), 32'h4);
    check("tag_grant",  32'(grant_b),  32'h2);
    check("tag_frames", 32'(frames),   32'd2);
    check("tag_byte0",  32'(fr[0]),    32'h82);
    check("tag_byte1",  32'(fr[1]),    32'h3C);

    // en dropped in WAIT_DONE of the tag frame: data byte still goes out.
    valid_b = 4'b1010; data_b = 32'h5E007100;
    pulses = 0; frames = 0; rdy_bits = '0; prev = 1'b0; seen = 1'b0; en_seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ready_b != 4'b0) begin pulses++; rdy_bits |= ready_b; valid_b = valid_b & ~ready_b; end
      if (start_b && !prev && frames < 4) begin
        fr[frames] = txdata_b;
        frames++;
        if (frames == 2) en_seen = txen_b;
      end
      if (!start_b && prev && frames == 1) en_b = 1'b0;
      prev = start_b;
      if (active_b) seen = 1'b1;
      if (seen && !active_b) break;
    end
    check("end_pulses", 32'(pulses),   32'd1);
    check("end_ready",  32'(rdy_bits), 32'h8);
    check("end_frames", 32'(frames),   32'd2);
    check("end_byte0",  32'(fr[0]),    32'h83);
    check("end_byte1",  32'(fr[1]),    32'h5E);
    check("end_txen_in_frame", 32'(en_seen), 32'h1);
    check("end_txen_idle",     32'(txen_b),  32'h0);
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ready_b != 4'b0 || active_b) quiet++;
    end
    check("end_no_grant", 32'(quiet), 32'd0);
    en_b = 1'b1;
    for (int n = 0; n < 50 && ready_b == 4'b0; n++) @(negedge clk);
    check("end_resume_ready", 32'(ready_b), 32'h2);
    check("end_resume_grant", 32'(grant_b), 32'h1);
    valid_b = '0;
    for (int n = 0; n < 200 && active_b; n++) @(negedge clk);

    // Asynchronous reset while in START (pointer on instance a is at 3).
    mtie[0] = 1'b1;
    valid_a = 4'b1000; data_a = 32'hE1000000;
    wait_ready_a();
    check("rs_ready", 32'(ready_a), 32'h8);
    valid_a = '0;
    repeat (3) @(negedge clk);
    check("rs_in_start", 32'(start_a), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_start",  32'(start_a),  32'h0);
    check("rs_active", 32'(active_a), 32'h0);
    check("rs_ready0", 32'(ready_a),  32'h0);
    check("rs_grant",  32'(grant_a),  32'h0);
    valid_a = 4'b1111; data_a = 32'h44332211;
    @(negedge clk);
    rst_n = 1'b1;
    mtie[0] = 1'b0;
    wait_ready_a();
    check("rs_first_ready",  32'(ready_a),  32'h1);
    check("rs_first_grant",  32'(grant_a),  32'h0);
    check("rs_first_txdata", 32'(txdata_a), 32'h11);
    valid_a = '0;
    wait_idle_a();
    check("rs_idle", 32'(active_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
